// File: rtl/blk_tracker.sv
// blk_tracker: block-grid position tracker with per-pixel luma weight for an RGB888 stream
// clk_i    pixel clock
// rst_ni   async active-low reset
// vs_i     vertical sync (rising edge starts a frame and clears all counters)
// de_i     data enable, ignored until the first vs_i rising edge after reset
// data_i   RGB888 pixel, R[23:16] G[15:8] B[7:0]
// vs_o     vs_i delayed by 2 cycles
// de_o     de_i delayed by 2 cycles
// ht_o     block column of the current output pixel, 0 while de_o is low
// vt_o     block row of the current output pixel
// h_save_o last pixel of a block on the last line of a block row
// v_save_o one-cycle pulse after de_o falls on the last line of a block row
// wd_o     per-pixel weight
// Macro BLK_TRACKER_WEIGHTED_EN: wd_o carries the full luma instead of the 0/1 threshold
module blk_tracker #(
   parameter int HBLKS   = 10,
   parameter int VBLKS   = 10,
   parameter int KH      = 192,
   parameter int KV      = 108,
   parameter int LUMA_TH = 128
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        vs_i,
   input  logic        de_i,
   input  logic [23:0] data_i,
   output logic        vs_o,
   output logic        de_o,
   output logic [31:0] ht_o,
   output logic [31:0] vt_o,
   output logic        h_save_o,
   output logic        v_save_o,
   output logic [7:0]  wd_o
);
   logic        armed, vs_q, de_q;
   logic        de_act, vs_rise, de_fall;
   logic [31:0] px, ht, ln, vt;
   logic        vs1, de1, hs1, vsv1;
   logic [31:0] ht1, vt1;
   logic [7:0]  y1;
   logic [10:0] y_sum;
`ifndef BLK_TRACKER_WEIGHTED_EN
   localparam logic [7:0] TH = LUMA_TH[7:0];
`endif
   always_comb begin
      y_sum   = {2'b0, data_i[23:16], 1'b0} + {1'b0, data_i[15:8], 2'b0}
              + {3'b0, data_i[15:8]} + {3'b0, data_i[7:0]};
      de_act  = armed & de_i;
      vs_rise = vs_i & ~vs_q;
      de_fall = de_q & ~de_act;
   end
   // ht/vt saturate in the counters themselves, so everything downstream sees clamped values
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         armed <= 1'b0;
         vs_q  <= 1'b0;
         de_q  <= 1'b0;
         px    <= '0;
         ht    <= '0;
         ln    <= '0;
         vt    <= '0;
      end else begin
         vs_q <= vs_i;
         de_q <= de_act;
         if (vs_rise) begin
            armed <= 1'b1;
            px    <= '0;
            ht    <= '0;
            ln    <= '0;
            vt    <= '0;
         end else if (de_act) begin
            px <= (px == KH - 1) ? '0 : px + 32'd1;
            if (px == KH - 1 && ht != HBLKS) ht <= ht + 32'd1;
         end else if (de_fall) begin
            px <= '0;
            ht <= '0;
            ln <= (ln == KV - 1) ? '0 : ln + 32'd1;
            if (ln == KV - 1 && vt != VBLKS) vt <= vt + 32'd1;
         end
      end
   end
   // stage 1 tags each pixel with the counter values it was counted under; stage 2 drives the ports
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vs1      <= 1'b0;
         de1      <= 1'b0;
         y1       <= '0;
         ht1      <= '0;
         vt1      <= '0;
         hs1      <= 1'b0;
         vsv1     <= 1'b0;
         vs_o     <= 1'b0;
         de_o     <= 1'b0;
         ht_o     <= '0;
         vt_o     <= '0;
         h_save_o <= 1'b0;
         v_save_o <= 1'b0;
         wd_o     <= '0;
      end else begin
         vs1      <= vs_i;
         de1      <= de_act;
         y1       <= 8'(y_sum >> 3);
         ht1      <= ht;
         vt1      <= vt;
         hs1      <= de_act && px == KH - 1 && ln == KV - 1 && ht < HBLKS;
         vsv1     <= de_fall && !vs_rise && ln == KV - 1 && vt < VBLKS;
         vs_o     <= vs1;
         de_o     <= de1;
         ht_o     <= de1 ? ht1 : '0;
         vt_o     <= vt1;
         h_save_o <= hs1;
         v_save_o <= vsv1;
`ifdef BLK_TRACKER_WEIGHTED_EN
         wd_o     <= de1 ? y1 : 8'd0;
`else
         wd_o     <= {7'd0, de1 && y1 >= TH};
`endif
      end
   end
endmodule

// File: tb/tb_blk_tracker.sv
// tb_blk_tracker: directed checks of blk_tracker with KH=4 KV=2 HBLKS=3 VBLKS=2
module tb_blk_tracker;
   logic        clk_i = 1'b0, rst_ni = 1'b0, vs_i = 1'b0, de_i = 1'b0;
   logic [23:0] data_i = '0;
   logic        vs_o, de_o, h_save_o, v_save_o;
   logic [31:0] ht_o, vt_o;
   logic [7:0]  wd_o;
   int n_run = 0, n_fail = 0;
`ifdef BLK_TRACKER_WEIGHTED_EN
   localparam logic [7:0] W_FF = 8'hFF, W_80 = 8'h80, W_7F = 8'h7F;
`else
   localparam logic [7:0] W_FF = 8'd1, W_80 = 8'd1, W_7F = 8'd0;
`endif
   typedef struct packed {
      logic vs, de;
      logic [31:0] ht, vt;
      logic hs, vsv;
      logic [7:0] wd;
   } exp_t;
   exp_t q[$];
   blk_tracker #(.HBLKS(3), .VBLKS(2), .KH(4), .KV(2), .LUMA_TH(128)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
      .vs_o(vs_o), .de_o(de_o), .ht_o(ht_o), .vt_o(vt_o),
      .h_save_o(h_save_o), .v_save_o(v_save_o), .wd_o(wd_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic zero_chk(input string tag);
      chk({tag, "_vs"}, {31'd0, vs_o}, 0);
      chk({tag, "_de"}, {31'd0, de_o}, 0);
      chk({tag, "_ht"}, ht_o, 0);
      chk({tag, "_vt"}, vt_o, 0);
      chk({tag, "_hs"}, {31'd0, h_save_o}, 0);
      chk({tag, "_vsv"}, {31'd0, v_save_o}, 0);
      chk({tag, "_wd"}, {24'd0, wd_o}, 0);
   endtask
   // outputs seen at a step belong to the inputs driven two steps earlier
   task automatic step(input logic vs, input logic de, input logic [23:0] d, input int eht,
                       input int evt, input logic ehs, input logic evsv, input logic [7:0] ewd,
                       input logic ede);
      exp_t e;
      @(negedge clk_i);
      if (q.size() == 2) begin
         e = q.pop_front();
         chk("vs_o", {31'd0, vs_o}, {31'd0, e.vs});
         chk("de_o", {31'd0, de_o}, {31'd0, e.de});
         chk("ht_o", ht_o, e.ht);
         chk("vt_o", vt_o, e.vt);
         chk("h_save_o", {31'd0, h_save_o}, {31'd0, e.hs});
         chk("v_save_o", {31'd0, v_save_o}, {31'd0, e.vsv});
         chk("wd_o", {24'd0, wd_o}, {24'd0, e.wd});
      end
      vs_i = vs; de_i = de; data_i = d;
      e = '{vs: vs, de: ede, ht: eht, vt: evt, hs: ehs, vsv: evsv, wd: ewd};
      q.push_back(e);
   endtask
   task automatic idle(input int n, input int evt);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, evt, 0, 0, 0, 0);
   endtask
   task automatic vsync(input int evt);
      step(1, 0, 0, 0, evt, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2, 0);
   endtask
   task automatic line(input int n, input logic [23:0] d, input logic [7:0] ewd, input logic hs_row,
                       input int vt_e, input int vt_a, input logic vsv, input int gap);
      for (int p = 0; p < n; p++)
         step(0, 1, d, (p / 4 > 3) ? 3 : p / 4, vt_e, hs_row && p % 4 == 3 && p < 12, 0, ewd, 1);
      for (int g = 0; g < gap; g++)
         step(0, 0, 0, 0, (g == 0) ? vt_e : vt_a, 0, vsv && g == 0, 0, 0);
   endtask
   initial begin
      repeat (3) @(negedge clk_i);
      zero_chk("rst");
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 1, 24'hFFFFFF, 0, 0, 0, 0, 0, 0);
      idle(2, 0);
      vsync(0);
      line(12, 24'hFFFFFF, W_FF, 0, 0, 0, 0, 3);
      line(12, 24'hFFFFFF, W_FF, 1, 0, 1, 1, 3);
      line(16, 24'h808080, W_80, 0, 1, 1, 0, 3);
      line(16, 24'h7F7F7F, W_7F, 1, 1, 2, 1, 1);
      line(16, 24'h808080, W_80, 0, 2, 2, 0, 3);
      line(16, 24'h7F7F7F, W_7F, 1, 2, 2, 0, 3);
      vsync(2);
      line(12, 24'hFFFFFF, W_FF, 0, 0, 0, 0, 3);
      vsync(0);
      line(12, 24'h808080, W_80, 0, 0, 0, 0, 3);
      line(12, 24'hFFFFFF, W_FF, 1, 0, 1, 1, 3);
      idle(2, 1);
      vsync(1);
      for (int p = 0; p < 5; p++) step(0, 1, 24'hFFFFFF, p / 4, 0, 0, 0, W_FF, 1);
      #2 rst_ni = 1'b0;
      #1 zero_chk("async_rst");
      q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 1, 24'hFFFFFF, 0, 0, 0, 0, 0, 0);
      idle(3, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
